aes_readout_ctrl: RTL and testbench

Sequencer that streams the 128-bit AES state out one byte at a time over a valid/ready byte interface.
- Drives the row select of the per-column 4:1 byte read mux and the column select of the state array.
- Captures the selected byte into an output register.
- Prefetches the next byte so a consumer that never stalls receives one byte per cycle.
- Sits between the iterative AES core's state registers and the host/capture interface.

---
 rtl/aes_readout_ctrl_if.sv | 22 ++
 rtl/aes_readout_ctrl.sv | 109 ++++++++++
 tb/tb_aes_readout_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_readout_ctrl_if.sv
// Byte-stream bus between the AES readout sequencer and its consumer.
// Valid/ready handshake with an end-of-readout marker.
interface aes_readout_ctrl_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/aes_readout_ctrl.sv
// Streams the 128-bit AES state out one byte per cycle, driving the state
// array read selects and prefetching the next byte while the current one waits.
module aes_readout_ctrl #(
  parameter int BYTE_ORDER = 0,
  parameter int NUM_BYTES  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [7:0]          byte_in,
  output logic [1:0]          row_sel,
  output logic [1:0]          col_sel,
  aes_readout_ctrl_if.master  stream,
  output logic                busy,
  output logic                done
);

  if (NUM_BYTES < 1 || NUM_BYTES > 16) begin : g_bad_num_bytes
    $error("aes_readout_ctrl: NUM_BYTES must be in 1..16");
  end

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_BYTES - 1);

  state_t     state;
  logic [3:0] idx;
  logic [3:0] sent;

  // idx always points at the byte to be captured on the next load/handshake,
  // so in SEND the mux already presents the following byte.
  if (BYTE_ORDER == 0) begin : g_col_major
    assign col_sel = idx[3:2];
    assign row_sel = idx[1:0];
  end else begin : g_row_major
    assign row_sel = idx[3:2];
    assign col_sel = idx[1:0];
  end

  assign busy = (state != IDLE);

  // NOTE: every register here, including the output byte, is cleared by the
  // asynchronous reset, and all state updates use non-blocking assignments so
  // the whole block reads pre-edge values consistently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      idx              <= '0;
      sent             <= '0;
      stream.out_data  <= '0;
      stream.out_valid <= 1'b0;
      stream.out_last  <= 1'b0;
      done             <= 1'b0;
    end else begin
      // NOTE: done defaults low each cycle so it can only ever be a single pulse.
      done <= 1'b0;
      if (abort) begin
        state            <= IDLE;
        idx              <= '0;
        sent             <= '0;
        stream.out_valid <= 1'b0;
        stream.out_last  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state <= LOAD;
              idx   <= '0;
              sent  <= '0;
            end
          end
          LOAD: begin
            stream.out_data  <= byte_in;
            stream.out_valid <= 1'b1;
            stream.out_last  <= (sent == LAST_IDX);
            idx              <= idx + 4'd1;
            state            <= SEND;
          end
          SEND: begin
            // Without a handshake everything holds, keeping the stream stable.
            if (stream.out_valid && stream.out_ready) begin
              if (stream.out_last) begin
                stream.out_valid <= 1'b0;
                stream.out_last  <= 1'b0;
                done             <= 1'b1;
                idx              <= '0;
                state            <= IDLE;
              end else begin
                stream.out_data <= byte_in;
                stream.out_last <= ((sent + 4'd1) == LAST_IDX);
                sent            <= sent + 4'd1;
                idx             <= idx + 4'd1;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_readout_ctrl.sv
// Randomized bench for aes_readout_ctrl: three instances (column-major,
// row-major, single byte) checked against an index-arithmetic stream model.
module tb_aes_readout_ctrl;

  logic       clk;
  logic       rst_n;
  logic [2:0] start_v;
  logic [2:0] abort_v;
  logic [2:0] ready_v;

  logic [7:0] mem [4][4];  // state array, indexed [col][row]

  logic [1:0] row0, col0, row1, col1, row2, col2;
  logic [7:0] byte0, byte1, byte2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;

  aes_readout_ctrl_if if0 ();
  aes_readout_ctrl_if if1 ();
  aes_readout_ctrl_if if2 ();

  assign if0.out_ready = ready_v[0];
  assign if1.out_ready = ready_v[1];
  assign if2.out_ready = ready_v[2];

  assign byte0 = mem[col0][row0];
  assign byte1 = mem[col1][row1];
  assign byte2 = mem[col2][row2];

  aes_readout_ctrl #(.BYTE_ORDER(0), .NUM_BYTES(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
    .byte_in(byte0), .row_sel(row0), .col_sel(col0), .stream(if0),
    .busy(busy0), .done(done0)
  );

  aes_readout_ctrl #(.BYTE_ORDER(1), .NUM_BYTES(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
    .byte_in(byte1), .row_sel(row1), .col_sel(col1), .stream(if1),
    .busy(busy1), .done(done1)
  );

  aes_readout_ctrl #(.BYTE_ORDER(0), .NUM_BYTES(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort_v[2]),
    .byte_in(byte2), .row_sel(row2), .col_sel(col2), .stream(if2),
    .busy(busy2), .done(done2)
  );

  typedef struct packed {
    logic       valid;
    logic       last;
    logic       busy;
    logic       done;
    logic [7:0] data;
    logic [1:0] row;
    logic [1:0] col;
  } obs_t;

  obs_t obs [3];

  always_comb begin
    obs[0] = {if0.out_valid, if0.out_last, busy0, done0, if0.out_data, row0, col0};
    obs[1] = {if1.out_valid, if1.out_last, busy1, done1, if1.out_data, row1, col1};
    obs[2] = {if2.out_valid, if2.out_last, busy2, done2, if2.out_data, row2, col2};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int order_of(input int d);
    return (d == 1) ? 1 : 0;
  endfunction

  function automatic int n_of(input int d);
    return (d == 2) ? 1 : 16;
  endfunction

  // Stream position k -> (row, col) straight from the readout-order rule.
  function automatic logic [3:0] exp_sel(input int d, input int k);
    int r, c;
    if (order_of(d) == 0) begin
      c = k / 4; r = k % 4;
    end else begin
      r = k / 4; c = k % 4;
    end
    return {2'(r), 2'(c)};
  endfunction

  function automatic logic [7:0] exp_byte(input int d, input int k);
    logic [3:0] rc;
    rc = exp_sel(d, k);
    return mem[rc[1:0]][rc[3:2]];
  endfunction

  task automatic fill_index();
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        mem[c][r] = 8'(4 * c + r);
  endtask

  task automatic fill_random();
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        mem[c][r] = 8'($urandom);
  endtask

  task automatic check_idle(input int d, input string tag);
    check({tag, "_valid"}, 32'(obs[d].valid), 0);
    check({tag, "_last"},  32'(obs[d].last), 0);
    check({tag, "_busy"},  32'(obs[d].busy), 0);
    check({tag, "_sel"},   32'({obs[d].row, obs[d].col}), 0);
  endtask

  // One readout on instance d, called and returning at a falling edge.
  // mode 0: always ready; 1: ready 1,0,0,1 then random; 2: random stalls.
  // abort_at: byte index at which abort is raised with ready (-1 none).
  // mid_start: cycle number at which start is pulsed while busy (-1 none).
  // chain: return in the done cycle so the next call starts right there.
  task automatic readout(input int d, input int mode, input int abort_at,
                         input int mid_start, input bit chain, input string tag);
    int         n, j, cyc, stalls, vcount;
    bit         stalled, rdy;
    logic [7:0] held_d;
    logic       held_l;
    bit         pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    n = n_of(d);
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    check({tag, "_load_valid"}, 32'(obs[d].valid), 0);
    check({tag, "_load_busy"},  32'(obs[d].busy), 1);
    check({tag, "_load_done"},  32'(obs[d].done), 0);
    check({tag, "_load_sel"},   32'({obs[d].row, obs[d].col}), 32'(exp_sel(d, 0)));
    j = 0; cyc = 1; stalls = 0; vcount = 0; stalled = 0;
    held_d = '0; held_l = 1'b0;
    while (j < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start_v[d] = (cyc == mid_start);
      check({tag, "_valid"}, 32'(obs[d].valid), 1);
      check({tag, "_busy"},  32'(obs[d].busy), 1);
      if (stalled) begin
        check({tag, "_hold_data"}, 32'(obs[d].data), 32'(held_d));
        check({tag, "_hold_last"}, 32'(obs[d].last), 32'(held_l));
      end
      check({tag, "_sel"}, 32'({obs[d].row, obs[d].col}), 32'(exp_sel(d, (j + 1) % 16)));
      if (j == abort_at) begin
        ready_v[d] = 1'b1;
        abort_v[d] = 1'b1;
        @(negedge clk);
        abort_v[d] = 1'b0;
        start_v[d] = 1'b0;
        check_idle(d, {tag, "_abort"});
        check({tag, "_abort_done"}, 32'(obs[d].done), 0);
        @(negedge clk);
        check({tag, "_abort_done2"}, 32'(obs[d].done), 0);
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (vcount < 4) ? pat[vcount] : ($urandom_range(0, 99) >= 40);
        default: rdy = ($urandom_range(0, 99) >= 40);
      endcase
      vcount++;
      ready_v[d] = rdy;
      if (rdy) begin
        check({tag, "_data"}, 32'(obs[d].data), 32'(exp_byte(d, j)));
        check({tag, "_last"}, 32'(obs[d].last), 32'(j == n - 1));
        j++;
        stalled = 1'b0;
      end else begin
        stalls++;
        stalled = 1'b1;
        held_d  = obs[d].data;
        held_l  = obs[d].last;
      end
    end
    start_v[d] = 1'b0;
    if (j < n) check({tag, "_timeout"}, 32'(j), 32'(n));
    check({tag, "_cycles"}, 32'(cyc), 32'(n + stalls + 1));
    @(negedge clk);
    check({tag, "_done"}, 32'(obs[d].done), 1);
    check_idle(d, {tag, "_end"});
    if (!chain) begin
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(obs[d].done), 0);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start_v = '0;
    abort_v = '0;
    ready_v = '0;
    fill_index();
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check_idle(d, "reset");
      check("reset_done", 32'(obs[d].done), 0);
      check("reset_data", 32'(obs[d].data), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Column-major and row-major streams of the indexed array, no stalls.
    readout(0, 0, -1, -1, 1'b0, "t1");
    readout(1, 0, -1, -1, 1'b0, "t2");

    // Random contents with the 1,0,0,1 pattern and random stalls.
    fill_random();
    readout(0, 1, -1, -1, 1'b0, "t3a");
    readout(1, 1, -1, -1, 1'b0, "t3b");
    readout(0, 2, -1, -1, 1'b0, "t3c");

    // Abort on the 6th byte with a simultaneous handshake, then a clean rerun.
    readout(0, 0, 5, -1, 1'b0, "t4");
    readout(0, 2, -1, -1, 1'b0, "t4b");

    // start while busy is ignored; start in the done cycle is accepted.
    fill_random();
    readout(0, 2, -1, 7, 1'b1, "t5a");
    readout(0, 0, -1, 3, 1'b0, "t5b");

    // abort together with start in IDLE drops the start.
    abort_v[0] = 1'b1;
    start_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    start_v[0] = 1'b0;
    check_idle(0, "abort_start");
    @(negedge clk);
    check("abort_start_busy2", 32'(obs[0].busy), 0);

    // Single-byte readouts.
    readout(2, 0, -1, -1, 1'b0, "t6a");
    readout(2, 2, -1, -1, 1'b1, "t6b");
    readout(2, 1, -1, -1, 1'b0, "t6c");

    // Asynchronous reset mid-stream, sampled before any rising edge.
    ready_v[0] = 1'b1;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_idle(0, "async_rst");
    check("async_rst_data", 32'(obs[0].data), 0);
    check("async_rst_done", 32'(obs[0].done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_done", 32'(obs[0].done), 0);
    readout(0, 2, -1, -1, 1'b0, "t6d");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
